// File: rtl/ah_credit_pkg.sv
// Shared defaults and helpers for the credit-based transmit stage.
// CNT_W sizes a counter that must represent 0..CREDITS inclusive.
package ah_credit_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CREDITS   = 10;
  localparam int DEF_BUF_DEPTH = 4;

  function automatic int CNT_W(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/ah_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers.
// The extra MSB on each pointer distinguishes full from empty when the indices match.
module ah_sync_fifo
  import ah_credit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ah_credit_tx.sv
// Credit-based transmit stage: buffers producer beats and forwards them as
// single-cycle write pulses to the downstream FIFO while credits are held.
module ah_credit_tx
  import ah_credit_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CREDITS   = DEF_CREDITS,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        credit_in,
  output logic [CNT_W(CREDITS)-1:0]   credit_cnt,
  output logic                        idle,
  output logic                        credit_err
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered occupancy, never on in_valid.

  localparam int CW = CNT_W(CREDITS);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [CW-1:0] C_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic              w_push;
  logic              w_issue;
  logic              w_full;
  logic              w_empty;
  logic [AW:0]       w_count;
  logic [DATA_W-1:0] w_head;
  logic [CW-1:0]     w_credit_nxt;
  logic              w_overflow;

  logic [CW-1:0]     r_credit_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_credit_err;

  ah_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_push  = in_valid && !w_full;
  // Issue looks only at pre-edge occupancy, so a beat pushed this edge waits a cycle.
  assign w_issue = !w_empty && (r_credit_cnt != '0);

  always_comb begin
    w_credit_nxt = r_credit_cnt;
    w_overflow   = 1'b0;
    if (w_issue && !credit_in) begin
      w_credit_nxt = r_credit_cnt - C_ONE;
    end else if (!w_issue && credit_in) begin
      if (r_credit_cnt == C_MAX) w_overflow = 1'b1;
      else                       w_credit_nxt = r_credit_cnt + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_credit_cnt <= C_MAX;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_credit_err <= 1'b0;
    end else begin
      r_credit_cnt <= w_credit_nxt;
      r_out_valid  <= w_issue;
      if (w_issue)    r_out_data   <= w_head;
      if (w_overflow) r_credit_err <= 1'b1;
    end
  end

  assign in_ready   = !w_full;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign credit_cnt = r_credit_cnt;
  assign credit_err = r_credit_err;
  assign idle       = (w_count == '0) && (r_credit_cnt == C_MAX);

endmodule

// File: tb/tb_ah_credit_tx.sv
// Bench for ah_credit_tx: queue/integer reference model stepped once per
// clock from the driver, plus an expected-beat queue for ordering.
module tb_ah_credit_tx;

  localparam int DATA_W    = 8;
  localparam int CREDITS   = 10;
  localparam int BUF_DEPTH = 4;
  localparam int CW        = $clog2(CREDITS + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              credit_in = 1'b0;
  logic [CW-1:0]     credit_cnt;
  logic              idle;
  logic              credit_err;

  ah_credit_tx #(
    .DATA_W    (DATA_W),
    .CREDITS   (CREDITS),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .credit_in  (credit_in),
    .credit_cnt (credit_cnt),
    .idle       (idle),
    .credit_err (credit_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];

  // reference model state
  logic [DATA_W-1:0] mq[$];
  int                m_credit;
  logic              m_ov;
  logic [DATA_W-1:0] m_od;
  logic              m_err;

  task automatic model_reset();
    mq.delete();
    m_credit = CREDITS;
    m_ov     = 1'b0;
    m_od     = '0;
    m_err    = 1'b0;
  endtask

  // Drive one cycle's inputs (in the low phase), advance the model by one
  // edge, then return at the following falling edge for sampling.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic ci);
    logic iss;
    logic acc;
    in_valid  = v;
    in_data   = d;
    credit_in = ci;
    iss = (mq.size() > 0) && (m_credit > 0);
    acc = v && (mq.size() < BUF_DEPTH);
    m_ov = iss;
    if (iss) m_od = mq.pop_front();
    if (acc) mq.push_back(d);
    if (iss && !ci) m_credit = m_credit - 1;
    else if (!iss && ci) begin
      if (m_credit == CREDITS) m_err = 1'b1;
      else                     m_credit = m_credit + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_total += 6;
    if (in_ready !== 1'b1)           begin n_bad++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    if (out_valid !== 1'b0)          begin n_bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    if (out_data !== '0)             begin n_bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    if (credit_cnt !== CW'(CREDITS)) begin n_bad++; $display("FAIL reset_credit_cnt got=%0d exp=%0d", credit_cnt, CREDITS); end
    if (idle !== 1'b1)               begin n_bad++; $display("FAIL reset_idle got=%0h exp=1", idle); end
    if (credit_err !== 1'b0)         begin n_bad++; $display("FAIL reset_credit_err got=%0h exp=0", credit_err); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_no_credit();
    int pulses = 0;
    logic [DATA_W-1:0] e;
    exp_q.delete();
    for (int i = 1; i <= 10; i++) exp_q.push_back(DATA_W'(i));
    for (int c = 0; c < 16; c++) begin
      cycle(c < 12, DATA_W'(c + 1), 1'b0);
      n_total += 3;
      if (out_valid !== m_ov)          begin n_bad++; $display("FAIL fill_out_valid c=%0d got=%0h exp=%0h", c, out_valid, m_ov); end
      if (credit_cnt !== CW'(m_credit)) begin n_bad++; $display("FAIL fill_credit c=%0d got=%0d exp=%0d", c, credit_cnt, m_credit); end
      if (in_ready !== 1'b1)           begin n_bad++; $display("FAIL fill_in_ready c=%0d got=%0h exp=1", c, in_ready); end
      if (out_valid === 1'b1) begin
        pulses++;
        n_total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (out_data !== e) begin n_bad++; $display("FAIL fill_data pulse=%0d got=%0h exp=%0h", pulses, out_data, e); end
      end
    end
    n_total += 2;
    if (pulses != 10)           begin n_bad++; $display("FAIL fill_pulses got=%0d exp=10", pulses); end
    if (credit_cnt !== '0)      begin n_bad++; $display("FAIL fill_credit_end got=%0d exp=0", credit_cnt); end
  endtask

  task automatic test_buffer_full();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, DATA_W'(8'h0D + i), 1'b0);
      n_total += 2;
      if (in_ready !== (mq.size() < BUF_DEPTH)) begin n_bad++; $display("FAIL full_in_ready i=%0d got=%0h exp=%0h", i, in_ready, mq.size() < BUF_DEPTH); end
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_out_valid i=%0d got=%0h exp=0", i, out_valid); end
    end
    cycle(1'b0, '0, 1'b0);
    n_total += 3;
    if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL full_in_ready_end got=%0h exp=0", in_ready); end
    if (idle !== 1'b0)      begin n_bad++; $display("FAIL full_idle got=%0h exp=0", idle); end
    if (credit_cnt !== '0)  begin n_bad++; $display("FAIL full_credit got=%0d exp=0", credit_cnt); end
  endtask

  task automatic test_credit_return();
    cycle(1'b0, '0, 1'b1);
    n_total += 2;
    if (credit_cnt !== CW'(1)) begin n_bad++; $display("FAIL ret_credit_1 got=%0d exp=1", credit_cnt); end
    if (out_valid !== 1'b0)    begin n_bad++; $display("FAIL ret_early_valid got=%0h exp=0", out_valid); end
    cycle(1'b0, '0, 1'b0);
    n_total += 4;
    if (out_valid !== 1'b1)    begin n_bad++; $display("FAIL ret_out_valid got=%0h exp=1", out_valid); end
    if (out_data !== 8'h0B)    begin n_bad++; $display("FAIL ret_out_data got=%0h exp=0b", out_data); end
    if (credit_cnt !== '0)     begin n_bad++; $display("FAIL ret_credit_0 got=%0d exp=0", credit_cnt); end
    if (in_ready !== 1'b1)     begin n_bad++; $display("FAIL ret_in_ready got=%0h exp=1", in_ready); end
  endtask

  // Entered with out_valid high and three beats still buffered.
  task automatic test_reset_mid();
    n_total++;
    if (idle !== 1'b0) begin n_bad++; $display("FAIL mid_pre_idle got=%0h exp=0", idle); end
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    n_total += 3;
    if (out_valid !== 1'b0)          begin n_bad++; $display("FAIL mid_async_valid got=%0h exp=0", out_valid); end
    if (credit_cnt !== CW'(CREDITS)) begin n_bad++; $display("FAIL mid_async_credit got=%0d exp=%0d", credit_cnt, CREDITS); end
    if (idle !== 1'b1)               begin n_bad++; $display("FAIL mid_async_idle got=%0h exp=1", idle); end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, '0, 1'b0);
      n_total += 3;
      if (out_valid !== 1'b0)          begin n_bad++; $display("FAIL mid_out_valid c=%0d got=%0h exp=0", c, out_valid); end
      if (idle !== 1'b1)               begin n_bad++; $display("FAIL mid_idle c=%0d got=%0h exp=1", c, idle); end
      if (credit_cnt !== CW'(CREDITS)) begin n_bad++; $display("FAIL mid_credit c=%0d got=%0d exp=%0d", c, credit_cnt, CREDITS); end
    end
  endtask

  task automatic test_loopback();
    logic [DATA_W-1:0] src[$];
    logic              ovh [0:299];
    logic [DATA_W-1:0] e;
    logic              ci;
    int sent = 0, n_out = 0, first = -1, last = -1, gaps = 0, min_cr = CREDITS;
    exp_q.delete();
    for (int i = 0; i < 50; i++) begin
      src.push_back(DATA_W'($urandom));
      exp_q.push_back(src[i]);
    end
    for (int c = 0; c < 300; c++) begin
      ci = (c >= 3) ? ovh[c-3] : 1'b0;
      if (sent < 50) begin
        if (mq.size() < BUF_DEPTH) begin
          cycle(1'b1, src[sent], ci);
          sent++;
        end else cycle(1'b1, src[sent], ci);
      end else cycle(1'b0, '0, ci);
      ovh[c] = out_valid;
      n_total += 2;
      if (out_valid !== m_ov)           begin n_bad++; $display("FAIL loop_out_valid c=%0d got=%0h exp=%0h", c, out_valid, m_ov); end
      if (credit_cnt !== CW'(m_credit)) begin n_bad++; $display("FAIL loop_credit c=%0d got=%0d exp=%0d", c, credit_cnt, m_credit); end
      if (out_valid === 1'b1) begin
        n_total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (out_data !== e) begin n_bad++; $display("FAIL loop_data n=%0d got=%0h exp=%0h", n_out, out_data, e); end
        n_out++;
        if (first < 0) first = c;
        last = c;
      end else if (first >= 0 && n_out < 50) gaps++;
      if (first >= 0 && c >= first + 3 && n_out < 50 && int'(credit_cnt) < min_cr) min_cr = int'(credit_cnt);
      if (n_out == 50 && c > last + 5) break;
    end
    n_total += 5;
    if (n_out != 50)                 begin n_bad++; $display("FAIL loop_count got=%0d exp=50", n_out); end
    if (gaps != 0)                   begin n_bad++; $display("FAIL loop_gaps got=%0d exp=0", gaps); end
    if (min_cr < 7)                  begin n_bad++; $display("FAIL loop_min_credit got=%0d exp>=7", min_cr); end
    if (credit_cnt !== CW'(CREDITS)) begin n_bad++; $display("FAIL loop_credit_end got=%0d exp=%0d", credit_cnt, CREDITS); end
    if (idle !== 1'b1)               begin n_bad++; $display("FAIL loop_idle got=%0h exp=1", idle); end
  endtask

  task automatic test_random();
    logic              v;
    logic              ci;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] e;
    exp_q.delete();
    for (int c = 0; c < 260; c++) begin
      if (c < 200) begin
        v  = ($urandom_range(0, 9) < 6);
        ci = ($urandom_range(0, 3) != 0) && (m_credit < CREDITS);
      end else begin
        v  = 1'b0;
        ci = (m_credit < CREDITS) && ($urandom_range(0, 1) == 1);
      end
      d = DATA_W'($urandom);
      if (v && mq.size() < BUF_DEPTH) exp_q.push_back(d);
      cycle(v, d, ci);
      n_total += 5;
      if (out_valid !== m_ov)           begin n_bad++; $display("FAIL rnd_out_valid c=%0d got=%0h exp=%0h", c, out_valid, m_ov); end
      if (credit_cnt !== CW'(m_credit)) begin n_bad++; $display("FAIL rnd_credit c=%0d got=%0d exp=%0d", c, credit_cnt, m_credit); end
      if (in_ready !== (mq.size() < BUF_DEPTH)) begin n_bad++; $display("FAIL rnd_in_ready c=%0d got=%0h exp=%0h", c, in_ready, mq.size() < BUF_DEPTH); end
      if (idle !== (mq.size() == 0 && m_credit == CREDITS)) begin n_bad++; $display("FAIL rnd_idle c=%0d got=%0h", c, idle); end
      if (credit_err !== 1'b0)          begin n_bad++; $display("FAIL rnd_credit_err c=%0d got=%0h exp=0", c, credit_err); end
      if (out_valid === 1'b1) begin
        n_total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (out_data !== e) begin n_bad++; $display("FAIL rnd_data c=%0d got=%0h exp=%0h", c, out_data, e); end
      end
      if (c >= 200 && mq.size() == 0 && m_credit == CREDITS && !m_ov) break;
    end
    n_total += 2;
    if (idle !== 1'b1)      begin n_bad++; $display("FAIL rnd_drain_idle got=%0h exp=1", idle); end
    if (exp_q.size() != 0)  begin n_bad++; $display("FAIL rnd_drain_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_credit_err();
    cycle(1'b0, '0, 1'b1);
    n_total += 2;
    if (credit_cnt !== CW'(CREDITS)) begin n_bad++; $display("FAIL err_credit got=%0d exp=%0d", credit_cnt, CREDITS); end
    if (credit_err !== 1'b1)         begin n_bad++; $display("FAIL err_set got=%0h exp=1", credit_err); end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, '0, 1'b0);
      n_total++;
      if (credit_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky c=%0d got=%0h exp=1", c, credit_err); end
    end
    rstn = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (credit_err !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%0h exp=0", credit_err); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill_no_credit();
    test_buffer_full();
    test_credit_return();
    test_reset_mid();
    test_loopback();
    test_random();
    test_credit_err();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ah_credit_tx.md
# ah_credit_tx

Credit-based transmit stage that sits directly upstream of the snoopable FIFO and drives its write port. It accepts beats from a producer over a valid/ready handshake and holds them in a small local buffer. It forwards a beat as a single-cycle write pulse only while it holds a credit. Credits start at the downstream FIFO depth and are replenished by single-cycle credit-return pulses.

## Interface
- DATA_W, 8, beat width
- CREDITS, 10, initial credit count; equals downstream FIFO depth
- BUF_DEPTH, 4, local buffer entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_data  in  DATA_W  producer beat
- in_valid  in  1  producer beat valid
- in_ready  out  1  buffer can accept a beat this cycle
- out_data  out  DATA_W  beat to downstream FIFO (wr_data)
- out_valid  out  1  one-cycle write pulse to downstream FIFO (wr_valid)
- credit_in  in  1  one-cycle credit return from downstream (wr_credit)
- credit_cnt  out  $clog2(CREDITS+1)  credits currently held
- idle  out  1  buffer empty and credit_cnt == CREDITS
- credit_err  out  1  sticky: credit returned while credit_cnt == CREDITS

## Operation
- Reset values: buffer empty, wr/rd pointers 0, in_ready 1, out_valid 0, out_data 0, credit_cnt = CREDITS, idle 1, credit_err 0.
- Accept: at the rising edge where in_valid && in_ready, in_data is written at the buffer write pointer.
- in_ready = !buf_full. It is derived from registered occupancy only, with no combinational path from in_valid.
- Issue condition: buf_count > 0 && credit_cnt > 0.
  - On the edge where this holds, the head beat is popped.
  - The head beat is registered into out_data, and out_valid is registered to 1.
  - Otherwise out_valid is registered to 0, and out_data holds its last value.
- At most one issue per cycle; back-to-back issues are allowed.
- Credit update: next = credit_cnt − issue + credit_in.
  - issue and credit_in on the same edge leave the count unchanged.
  - If credit_in arrives with credit_cnt == CREDITS and no issue on that edge: the count holds at CREDITS and credit_err sets. credit_err is cleared only by reset.
- Buffer pointers are BUF_DEPTH-modulo with one extra wrap bit.
  - full: indices equal, wrap bits differ.
  - empty: pointers fully equal.
- Simultaneous accept and issue on a full buffer is not possible because in_ready = 0. On a non-full buffer both happen, and occupancy is unchanged.
- A beat accepted into an empty buffer is not issued on the same edge; issue reads only pre-edge occupancy.
- Reset mid-operation: all buffered beats are discarded, credits restore to CREDITS, and out_valid drops immediately (asynchronously).
  - The downstream FIFO is reset by the same rstn, so no credit reconciliation is needed.

## Timing
- Accept-to-out_valid latency: 2 cycles minimum.
  - Beat written at edge k; issued at edge k+1; out_valid high in cycle k+1..k+2.
- Credit-to-issue: credit_in sampled at edge k is counted at edge k. It can enable an issue at edge k+1.
- Steady-state throughput is one beat per cycle while credits ≥ 1 each cycle. Full rate sustained needs a round-trip credit latency ≤ CREDITS cycles.
- out_valid is a registered output and is never held high for a single beat across multiple cycles.
- Combinational outputs: in_ready, idle. credit_cnt is a register.

## Structure
- Package ah_credit_pkg holds:
  - default DATA_W, CREDITS, BUF_DEPTH constants
  - credit-counter width function CNT_W(CREDITS) = $clog2(CREDITS+1)
- Sub-module ah_sync_fifo: BUF_DEPTH × DATA_W storage with wrap-bit pointers, providing push, pop, head data, full, empty, count.
- Top level contains the credit counter, issue register, and error flag.

## Test plan
- Reset → in_ready=1, out_valid=0, credit_cnt=10, idle=1, credit_err=0. Assert rstn mid-stream with 3 beats buffered → buffer empties, credit_cnt=10 on release.
- Push 12 beats 0x01..0x0C back-to-back, credit_in held 0 → exactly 10 out_valid pulses carrying 0x01..0x0A. credit_cnt reaches 0, 2 beats remain buffered, in_ready stays 1.
- Continue from above with 4 more pushes → buffer holds 4 beats (0x0B..0x0E), in_ready=0; extra in_valid is not accepted.
- Continue: one credit_in pulse → exactly one out_valid, with 0x0B, on the following cycle. credit_cnt goes 0→1→0, and in_ready returns to 1.
- Loopback with credit_in = out_valid delayed 3 cycles, 50 random beats → 50 beats out in order, no gaps after warm-up, credit_cnt never below 7 in steady state.
- credit_in pulse while idle (credit_cnt=10) → credit_cnt stays 10, credit_err=1 and remains set until reset.
